// File: rtl/slow_line_memory.sv
// =============================================================================
// Module   : slow_line_memory
// Brief    : Fixed-latency 128-bit line backing memory for the D-cache refill
//            and write-back port. Optional macro SLOW_MEM_VAR_LATENCY_EN adds
//            LFSR-driven extra latency of 0..3 cycles per request.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module slow_line_memory #(
    parameter int ADDR_W  = 28,
    parameter int LINE_W  = 128,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_ready
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   lat_m1;
    logic [1:0]         extra;
    logic               accept;
    logic               op_write;
    logic [IDX_W-1:0]   idx;
    logic [LINE_W-1:0]  wdata_q;
    logic [LINE_W-1:0]  rdata_q;
    logic [LINE_W-1:0]  mem [DEPTH];
    logic               unused_addr_bits;

    assign unused_addr_bits = ^mem_addr[ADDR_W-1:IDX_W];
    assign accept = (state == IDLE) && (mem_read || mem_write);

`ifdef SLOW_MEM_VAR_LATENCY_EN
    logic [3:0] lfsr;

    // x^4+x^3+1, stepped only when a request is accepted
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr <= 4'b0001;
        end else if (accept) begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
    end

    assign extra = lfsr[1:0];
`else
    assign extra = 2'b00;
`endif

    // Counter holds remaining WAIT cycles; READY is reached exactly
    // LATENCY(+extra) edges after the accepting edge.
    assign lat_m1 = CNT_W'(LATENCY - 1) + CNT_W'(extra);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = WAIT;
                    cnt_nxt   = lat_m1;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = READY;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            READY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rdata_q <= ((state_nxt == READY) && !op_write) ? mem[idx] : '0;
        end
    end

    // Request capture; write wins when read and write are both asserted
    always_ff @(posedge clk) begin
        if (accept) begin
            op_write <= mem_write;
            idx      <= mem_addr[IDX_W-1:0];
            wdata_q  <= mem_wdata;
        end
    end

    // Array is never cleared; reset on the commit edge suppresses the write
    always_ff @(posedge clk) begin
        if (rst && (state == READY) && op_write) begin
            mem[idx] <= wdata_q;
        end
    end

    assign mem_ready = (state == READY);
    assign mem_rdata = rdata_q;

endmodule

`default_nettype wire
